// File: rtl/cross_bar_pkg.sv
// cross_bar_pkg
// Shared types for the crossbar slave-side responder and its response pipe.
// Contents:
//   CB_ADDR_W / CB_DATA_W : default request address / data widths
//   cmd_e                 : request command encoding (read / write)
//   resp_state_e          : responder handshake FSM states
//   resp_entry_t          : one slot of the read-response delay line
//   resp_entry_make       : builds a delay-line entry, zeroing data when invalid
package cross_bar_pkg;

  localparam int CB_ADDR_W = 32;
  localparam int CB_DATA_W = 32;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } resp_state_e;

  typedef struct packed {
    logic                 valid;
    logic [CB_DATA_W-1:0] data;
  } resp_entry_t;

  // Empty slots always carry zero data so the pipe output can drive rdata
  // directly and still read as 0 in idle cycles.
  function automatic resp_entry_t resp_entry_make(input logic valid,
                                                  input logic [CB_DATA_W-1:0] data);
    resp_entry_t e;
    e.valid = valid;
    if (valid) begin
      e.data = data;
    end else begin
      e.data = {CB_DATA_W{1'b0}};
    end
    return e;
  endfunction

endpackage

// File: rtl/cross_bar_resp_delay_line.sv
// cross_bar_resp_delay_line
// Fixed-latency shift register of resp_entry_t. An entry written on one edge
// appears at out_entry STAGES edges later. Accepts one entry per cycle and
// never stalls. Async active-low reset empties every stage.
// Ports:
//   clk       in  system clock, rising edge
//   rst_n     in  asynchronous active-low reset
//   in_entry  in  entry pushed at every rising edge
//   out_entry out entry from the last stage (registered)
module cross_bar_resp_delay_line
  import cross_bar_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  resp_entry_t in_entry,
  output resp_entry_t out_entry
);

  resp_entry_t stage_r [STAGES];

  // Shift entries one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= in_entry;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign out_entry = stage_r[STAGES-1];

endmodule

// File: rtl/cross_bar_slave_responder.sv
// cross_bar_slave_responder
// Memory-backed responder for one slave port of the 4x4 crossbar. Requests
// are acknowledged ACK_DELAY cycles after req is first sampled high; writes
// update the scratch RAM at the accept edge, reads are returned RESP_DELAY
// cycles after the ack cycle through a fixed-latency pipe. Violations of the
// hold-until-accept rule raise a sticky proto_err.
// Ports:
//   clk       in  1       system clock, rising edge
//   rst_n     in  1       asynchronous active-low reset
//   req       in  1       request valid
//   addr      in  ADDR_W  byte address; only the word-index bits are used
//   cmd       in  1       0 = read, 1 = write
//   wdata     in  DATA_W  write data
//   ack       out 1       request accepted (one-cycle registered pulse)
//   resp      out 1       read response valid (one-cycle pulse)
//   rdata     out DATA_W  read data, zero whenever resp is low
//   proto_err out 1       sticky protocol-violation flag
module cross_bar_slave_responder
  import cross_bar_pkg::*;
#(
  parameter int ADDR_W     = CB_ADDR_W,
  parameter int DATA_W     = CB_DATA_W,
  parameter int DEPTH      = 16,
  parameter int ADDR_LSB   = 2,
  parameter int ACK_DELAY  = 1,
  parameter int RESP_DELAY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cmd,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              resp,
  output logic [DATA_W-1:0] rdata,
  output logic              proto_err
);

  localparam int IDX_W = $clog2(DEPTH);
  // Counter only needs to reach ACK_DELAY-1.
  localparam int CNT_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

  resp_state_e       state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] cap_addr_r;
  cmd_e              cap_cmd_r;
  logic [DATA_W-1:0] cap_wdata_r;
  logic              ack_r;
  logic              err_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  cmd_e              cmd_s;
  logic [IDX_W-1:0]  cap_idx_s;
  logic              accept_s;
  logic              mismatch_s;
  resp_entry_t       push_s;
  resp_entry_t       pop_s;

  assign cmd_s      = cmd_e'(cmd);
  assign cap_idx_s  = cap_addr_r[ADDR_LSB +: IDX_W];
  assign accept_s   = req & ack_r;
  assign mismatch_s = (addr != cap_addr_r) || (cmd_s != cap_cmd_r) ||
                      (wdata != cap_wdata_r);

  // Handshake FSM: captures the request, counts the ack delay, raises the
  // registered ack for one cycle and flags hold-rule violations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      cap_addr_r  <= {ADDR_W{1'b0}};
      cap_cmd_r   <= CMD_READ;
      cap_wdata_r <= {DATA_W{1'b0}};
      ack_r       <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ack_r <= 1'b0;
          if (req) begin
            cap_addr_r  <= addr;
            cap_cmd_r   <= cmd_s;
            cap_wdata_r <= wdata;
            if (ACK_DELAY == 1) begin
              state_r <= ACK;
              ack_r   <= 1'b1;
            end else begin
              state_r <= WAIT;
              cnt_r   <= CNT_W'(1);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (!req) begin
            // Request withdrawn before accept: abandon it.
            err_r   <= 1'b1;
            state_r <= IDLE;
            ack_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            // A changed request is flagged but the original capture is kept
            // and the ack countdown continues.
            if (mismatch_s) begin
              err_r <= 1'b1;
            end
            if (cnt_r == CNT_W'(ACK_DELAY - 1)) begin
              state_r <= ACK;
              ack_r   <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        ACK: begin
          state_r <= IDLE;
          ack_r   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          ack_r   <= 1'b0;
        end
      endcase
    end
  end

  // Scratch RAM: cleared on reset, written with the captured data at the
  // accept edge of a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (accept_s && (cap_cmd_r == CMD_WRITE)) begin
      mem_r[cap_idx_s] <= cap_wdata_r;
    end
  end

  // Read entry entering the response pipe; empty (zero) in every other cycle.
  always_comb begin
    push_s = '0;
    if (accept_s && (cap_cmd_r == CMD_READ)) begin
      push_s = resp_entry_make(1'b1, CB_DATA_W'(mem_r[cap_idx_s]));
    end else begin
      push_s = resp_entry_make(1'b0, {CB_DATA_W{1'b0}});
    end
  end

  cross_bar_resp_delay_line #(
    .STAGES (RESP_DELAY)
  ) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_entry  (push_s),
    .out_entry (pop_s)
  );

  assign ack       = ack_r;
  assign proto_err = err_r;
  assign resp      = pop_s.valid;
  assign rdata     = DATA_W'(pop_s.data);

endmodule

// File: tb/tb_cross_bar_slave_responder.sv
module tb_cross_bar_slave_responder;
  import cross_bar_pkg::*;

  localparam int RD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        cmd;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        ack1, resp1, err1;
  logic [31:0] rdata1;
  logic        ack3, resp3, err3;
  logic [31:0] rdata3;
  logic        ack4, resp4, err4;
  logic [31:0] rdata4;

  logic        ack_v, resp_v, err_v;
  logic [31:0] rdata_v;

  int cyc = 0;
  int sel = 1;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;
  exp_t expq[$];

  typedef struct {
    logic        c;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    int          gap;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cross_bar_slave_responder #(.ACK_DELAY(1), .RESP_DELAY(RD)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .cmd(cmd), .wdata(wdata),
    .ack(ack1), .resp(resp1), .rdata(rdata1), .proto_err(err1));
  cross_bar_slave_responder #(.ACK_DELAY(3), .RESP_DELAY(RD)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .cmd(cmd), .wdata(wdata),
    .ack(ack3), .resp(resp3), .rdata(rdata3), .proto_err(err3));
  cross_bar_slave_responder #(.ACK_DELAY(4), .RESP_DELAY(RD)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .cmd(cmd), .wdata(wdata),
    .ack(ack4), .resp(resp4), .rdata(rdata4), .proto_err(err4));

  // Outputs of the instance under test in the current section.
  always_comb begin
    case (sel)
      3: begin ack_v = ack3; resp_v = resp3; rdata_v = rdata3; err_v = err3; end
      4: begin ack_v = ack4; resp_v = resp4; rdata_v = rdata4; err_v = err4; end
      default: begin ack_v = ack1; resp_v = resp1; rdata_v = rdata1; err_v = err1; end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard side: pop an expectation for every resp pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (resp_v) begin
        if (expq.size() == 0) begin
          check("resp_without_request", 32'(resp_v), 32'd0);
        end else begin
          e = expq.pop_front();
          check("resp_cycle", cyc, e.cyc);
          check("resp_rdata", rdata_v, e.data);
        end
      end else begin
        check("rdata_idle_zero", rdata_v, 32'd0);
      end
    end
  end

  // Drive one request at a negedge, check ack timing, leave req asserted
  // on return (one cycle after the ack cycle).
  task automatic issue(input logic c, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input int ad);
    int   t0;
    exp_t e;
    t0 = cyc;
    req = 1'b1; cmd = c; addr = a; wdata = d;
    for (int n = 1; n <= ad; n++) begin
      @(negedge clk);
      check("ack_timing", 32'(ack_v), (n == ad) ? 32'd1 : 32'd0);
    end
    if (c == CMD_READ) begin
      e.cyc  = t0 + ad + RD;
      e.data = exp_rd;
      expq.push_back(e);
    end
    @(negedge clk);
    check("ack_single_pulse", 32'(ack_v), 32'd0);
  endtask

  task automatic do_reset();
    req   = 1'b0;
    rst_n = 1'b0;
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
    check("queue_drained", expq.size(), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0000, 0};
    tbl[1] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 32'hDEAD_BEEF, 2};
    tbl[2] = '{1'b1, 32'hC000_0004, 32'h1234_5678, 32'h0000_0000, 0};
    tbl[3] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'h1234_5678, 0};
    tbl[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0};
    tbl[5] = '{1'b1, 32'h0000_003C, 32'hA5A5_A5A5, 32'h0000_0000, 1};
    tbl[6] = '{1'b0, 32'h0000_007C, 32'h0000_0000, 32'hA5A5_A5A5, 0};
    tbl[7] = '{1'b0, 32'hFFFF_FFC8, 32'h0000_0000, 32'hDEAD_BEEF, 0};

    rst_n = 1'b0; req = 1'b0; cmd = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_resp1", 32'(resp1), 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_err1", 32'(err1), 32'd0);
    check("rst_ack3", 32'(ack3), 32'd0);
    check("rst_err3", 32'(err3), 32'd0);
    check("rst_ack4", 32'(ack4), 32'd0);
    check("rst_err4", 32'(err4), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ACK_DELAY=1: table of writes/reads incl. aliasing upper address bits.
    sel = 1;
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].c, tbl[i].a, tbl[i].d, tbl[i].exp, 1);
      if (tbl[i].gap > 0) begin
        req = 1'b0;
        repeat (tbl[i].gap) @(negedge clk);
      end
    end
    drain(4);
    check("err_clean_ad1", 32'(err_v), 32'd0);

    // ACK_DELAY=3: back-to-back reads, acks at +3 and +7, ordered responses.
    do_reset();
    sel = 3;
    issue(1'b1, 32'h0000_0004, 32'h0000_0011, 32'd0, 3);
    issue(1'b1, 32'h0000_0008, 32'h0000_0022, 32'd0, 3);
    req = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h0000_0004, 32'd0, 32'h0000_0011, 3);
    issue(1'b0, 32'h0000_0008, 32'd0, 32'h0000_0022, 3);
    drain(4);
    check("err_clean_ad3", 32'(err_v), 32'd0);

    // ACK_DELAY=3: address changes while waiting.
    req = 1'b1; cmd = 1'b1; addr = 32'h0000_0010; wdata = 32'h0000_0055;
    @(negedge clk);
    check("err_before_change", 32'(err_v), 32'd0);
    addr = 32'h0000_0014;
    @(negedge clk);
    check("err_addr_change", 32'(err_v), 32'd1);
    repeat (3) @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    check("err_sticky_ad3", 32'(err_v), 32'd1);

    // ACK_DELAY=4: req withdrawn after two cycles.
    do_reset();
    sel = 4;
    req = 1'b1; cmd = 1'b0; addr = 32'h0000_0000; wdata = 32'd0;
    repeat (2) begin
      @(negedge clk);
      check("no_ack_drop", 32'(ack_v), 32'd0);
    end
    req = 1'b0;
    @(negedge clk);
    check("err_drop", 32'(err_v), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("no_ack_after_drop", 32'(ack_v), 32'd0);
    end
    issue(1'b1, 32'h0000_0014, 32'h0000_0077, 32'd0, 4);
    issue(1'b0, 32'h0000_0014, 32'd0, 32'h0000_0077, 4);
    drain(4);
    check("err_sticky_ad4", 32'(err_v), 32'd1);

    // ACK_DELAY=1: reset one cycle after a read ack discards the response.
    do_reset();
    sel = 1;
    issue(1'b1, 32'h0000_000C, 32'h0000_0033, 32'd0, 1);
    issue(1'b0, 32'h0000_000C, 32'd0, 32'h0000_0033, 1);
    req = 1'b0;
    rst_n = 1'b0;
    expq.delete();
    repeat (2) @(negedge clk);
    check("resp_in_reset", 32'(resp_v), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("err_after_reset", 32'(err_v), 32'd0);
    issue(1'b0, 32'h0000_000C, 32'd0, 32'h0000_0000, 1);
    drain(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
